// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the buffered UART transmitter: parity
//            mode constants, FSM state encoding and the baud divider helpers.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode selectors for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Transmitter FSM encoding
    localparam int              ST_W      = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_START  = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
    localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
    localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

    // Clock cycles per bit, truncating; a non-positive baud rate yields 0 so
    // the range check below rejects it instead of dividing by zero.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (baud_rate > 0) ? (clk_freq / baud_rate) : 0;
    endfunction

    // A bit must last at least two cycles for the baud counter to work.
    function automatic bit div_ok(input int div);
        return div >= 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Purpose  : Single-clock FIFO holding words waiting for transmission.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_push/i_data - write strobe and word (ignored while full)
//            i_pop         - read strobe (ignored while empty)
//            o_data        - head word, valid while not empty
//            o_full/o_empty- occupancy flags
//            o_count       - number of stored words
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered UART transmitter. Words enter a FIFO through a
//            valid/ready handshake; the FSM frames each word (start, data
//            LSB first, optional parity, 1 or 2 stop bits) and sends queued
//            frames back-to-back.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            in_data     - word to transmit
//            in_valid    - in_data valid
//            in_ready    - FIFO has room; transfer when in_valid & in_ready
//            tx          - registered serial line, idle high
//            tx_busy     - a frame is on the line
//            tx_done     - one-cycle pulse as the last stop bit completes
//            fifo_count  - queued words, excluding the frame in flight
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_div    = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int c_baud_w = (c_div > 2) ? $clog2(c_div) : 1;
    localparam int c_bit_w  = 4;

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_div - 1);
    localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

    // ---------------------------------------------------------------- checks
    if (!div_ok(c_div)) begin : g_chk_div
        $fatal(1, "uart_tx_fifo: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $fatal(1, "uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_chk_parity
        $fatal(1, "uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop_bits
        $fatal(1, "uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    // ------------------------------------------------------------------ FIFO
    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign in_ready = ~w_fifo_full;

    // ----------------------------------------------------------- transmitter
    logic [ST_W-1:0]      r_state;
    logic [c_baud_w-1:0]  r_baud_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_tx_done;

    logic [ST_W-1:0]      w_state_nxt;
    logic [c_baud_w-1:0]  w_baud_nxt;
    logic [c_bit_w-1:0]   w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_parity_nxt;
    logic                 w_tx_nxt;
    logic                 w_done_nxt;
    logic                 w_load;
    logic                 w_tick;
    logic                 w_load_parity;

    // Parity is taken from the word as it leaves the FIFO, because the shift
    // register no longer holds the whole word by the time the bit is sent.
    assign w_load_parity = (PARITY == PARITY_EVEN) ? (^w_fifo_data) : (~^w_fifo_data);

    // Last cycle of the current bit
    assign w_tick = (r_baud_cnt == c_baud_last);

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = w_tick ? '0 : (r_baud_cnt + c_baud_w'(1));
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tx_nxt     = r_tx;
        w_done_nxt   = 1'b0;
        w_pop        = 1'b0;
        w_load       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                w_tx_nxt   = 1'b1;
                if (!w_fifo_empty) begin
                    w_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_data_last) begin
                        w_bit_nxt = '0;
                        if (PARITY != PARITY_NONE) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        // tx is registered, so present the bit after the one
                        // currently shifting out.
                        w_bit_nxt   = r_bit_cnt + c_bit_w'(1);
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_stop_last) begin
                        w_done_nxt = 1'b1;
                        w_bit_nxt  = '0;
                        if (!w_fifo_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Shared by IDLE and the end of STOP so back-to-back frames need no
        // idle cycle in between.
        if (w_load) begin
            w_pop        = 1'b1;
            w_shift_nxt  = w_fifo_data;
            w_parity_nxt = w_load_parity;
            w_state_nxt  = ST_START;
            w_tx_nxt     = 1'b0;
            w_baud_nxt   = '0;
            w_bit_nxt    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_done  <= w_done_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = (r_state != ST_IDLE);
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire
